bmp_blitter: RTL and testbench

BMP_BLITTER -- requirements
Module: bmp_blitter

---
 rtl/bmp_pkg.sv | 22 ++
 rtl/bmp_raster_ctr.sv | 37 +++
 rtl/bmp_blitter.sv | 183 ++++++++++++++++++
 tb/tb_bmp_blitter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared types and colour defaults for the bitmap blitter
package bmp_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_REMOVE = 2'b01,
        OP_FONT   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_X,
        S_HDR_Y,
        S_PIX,
        S_FIN
    } state_e;

    localparam logic [8:0] TRANSP_DEFAULT   = 9'h088;
    localparam logic [8:0] BG_COLOR_DEFAULT = 9'h000;

endpackage

// File: rtl/bmp_raster_ctr.sv
// rtl/bmp_raster_ctr.sv - column/row raster counters with wrap and last-pixel flags
module bmp_raster_ctr #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    input  logic [DW-1:0] width,
    input  logic [DW-1:0] height,
    output logic [DW-1:0] col,
    output logic [DW-1:0] row,
    output logic          col_last,
    output logic          last
);

    assign col_last = (col == width - DW'(1));
    assign last     = col_last && (row == height - DW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col_last) begin
                col <= '0;
                row <= row + DW'(1);
            end else begin
                col <= col + DW'(1);
            end
        end
    end

endmodule

// File: rtl/bmp_blitter.sv
// rtl/bmp_blitter.sv - copies ROM images and font glyphs into a framebuffer with clipping
module bmp_blitter
    import bmp_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int PIX_W   = 9,
    parameter int NUM_SRC = 4,
    parameter int ROM_AW  = 16,
    parameter int GLYPH_W = 13,
    parameter int GLYPH_H = 16,
    parameter int SHEET_W = 544,
    parameter logic [PIX_W-1:0] TRANSP   = PIX_W'(TRANSP_DEFAULT),
    parameter logic [PIX_W-1:0] BG_COLOR = PIX_W'(BG_COLOR_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [$clog2(NUM_SRC)-1:0]     req_src,
    input  logic [5:0]                     req_glyph,
    input  logic [$clog2(H_RES)-1:0]       req_x,
    input  logic [$clog2(V_RES)-1:0]       req_y,
    output logic [$clog2(NUM_SRC)-1:0]     rom_sel,
    output logic [ROM_AW-1:0]              rom_addr,
    input  logic [PIX_W-1:0]               rom_rdata,
    output logic [$clog2(H_RES*V_RES)-1:0] waddr,
    output logic [PIX_W-1:0]               wdata,
    output logic                           we,
    output logic                           done
);

    localparam int XW  = $clog2(H_RES);
    localparam int YW  = $clog2(V_RES);
    localparam int SW  = $clog2(NUM_SRC);
    localparam int WAW = $clog2(H_RES * V_RES);
    localparam int DW  = PIX_W;
    localparam int CXW = ((XW > DW) ? XW : DW) + 1;
    localparam int CYW = ((YW > DW) ? YW : DW) + 1;
    localparam logic [ROM_AW-1:0] FONT_ROW_STEP = ROM_AW'(SHEET_W - GLYPH_W + 1);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [SW-1:0]       sel_q;
    logic [DW-1:0]       width_q, height_q;
    logic [ROM_AW-1:0]   addr_q;
    logic [WAW-1:0]      waddr_q, row_start_q;
    logic                prime_q;
    logic [DW-1:0]       col, row;
    logic                col_last, last, slot;
    logic [CXW-1:0]      cx;
    logic [CYW-1:0]      cy;
    logic [WAW-1:0]      base;

    // PIX spends its first cycle issuing the first pixel address (and, for images, taking ywid)
    assign slot = (state_q == S_PIX) && !prime_q;
    assign base = WAW'(req_y) * WAW'(H_RES) + WAW'(req_x);
    assign cx   = CXW'(x_q) + CXW'(col);
    assign cy   = CYW'(y_q) + CYW'(row);

    bmp_raster_ctr #(.DW(DW)) u_raster (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!slot),
        .step     (slot),
        .width    (width_q),
        .height   (height_q),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .last     (last)
    );

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_FIN);
    assign rom_sel   = sel_q;
    assign waddr     = waddr_q;
    assign wdata     = (op_q == OP_REMOVE) ? BG_COLOR : rom_rdata;
    assign we        = slot && (rom_rdata != TRANSP) &&
                       (cx < CXW'(H_RES)) && (cy < CYW'(V_RES));

    // Address runs one pixel ahead of the write slot because the ROM has one cycle latency
    always_comb begin
        rom_addr = addr_q;
        if (slot)
            rom_addr = addr_q + (!col_last ? ROM_AW'(1) :
                                 (op_q == OP_FONT) ? FONT_ROW_STEP : ROM_AW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_ADD, OP_REMOVE: state_d = S_HDR_X;
                        OP_FONT:           state_d = S_PIX;
                        default:           state_d = S_FIN;
                    endcase
                end
            end
            S_HDR_X: state_d = S_HDR_Y;
            S_HDR_Y: state_d = S_PIX;
            S_PIX: begin
                if (prime_q) begin
                    if (op_q != OP_FONT && (width_q == '0 || rom_rdata == '0))
                        state_d = S_FIN;
                end else if (last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_ADD;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            addr_q      <= '0;
            waddr_q     <= '0;
            row_start_q <= '0;
            prime_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    prime_q <= 1'b0;
                    addr_q  <= '0;
                    if (req_valid) begin
                        op_q        <= op_e'(req_op);
                        x_q         <= req_x;
                        y_q         <= req_y;
                        waddr_q     <= base;
                        row_start_q <= base;
                        sel_q       <= req_src;
                        if (op_e'(req_op) == OP_FONT) begin
                            sel_q    <= '0;
                            width_q  <= DW'(GLYPH_W);
                            height_q <= DW'(GLYPH_H);
                            addr_q   <= ROM_AW'(req_glyph) * ROM_AW'(GLYPH_W);
                            prime_q  <= 1'b1;
                        end
                    end
                end
                S_HDR_X: addr_q <= ROM_AW'(1);
                S_HDR_Y: begin
                    addr_q  <= ROM_AW'(2);
                    width_q <= rom_rdata;
                    prime_q <= 1'b1;
                end
                S_PIX: begin
                    if (prime_q) begin
                        prime_q <= 1'b0;
                        if (op_q != OP_FONT) height_q <= rom_rdata;
                    end else begin
                        addr_q <= rom_addr;
                        if (col_last) begin
                            waddr_q     <= row_start_q + WAW'(H_RES);
                            row_start_q <= row_start_q + WAW'(H_RES);
                        end else begin
                            waddr_q <= waddr_q + WAW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_blitter.sv
// tb/tb_bmp_blitter.sv - directed table-driven bench for bmp_blitter
module tb_bmp_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [1:0]  req_src = '0;
    logic [5:0]  req_glyph = '0;
    logic [9:0]  req_x = '0;
    logic [8:0]  req_y = '0;
    logic [1:0]  rom_sel;
    logic [15:0] rom_addr;
    logic [8:0]  rom_rdata = '0;
    logic [18:0] waddr;
    logic [8:0]  wdata;
    logic        we;
    logic        done;

    logic [8:0]  img [4][8];
    int          wa[$];
    int          wd[$];
    int          ra[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0] op;
        logic [1:0] src;
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] words [6];
        int         n_exp;
        int         lat;
        int         ea [4];
        int         ed [4];
    } vec_t;

    vec_t vecs [8];

    bmp_blitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_glyph (req_glyph),
        .req_x     (req_x),
        .req_y     (req_y),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .waddr     (waddr),
        .wdata     (wdata),
        .we        (we),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Source 0 is a synthetic font sheet whose pixels never equal the colour key
    always @(posedge clk) begin
        if (rom_sel == 2'd0)
            rom_rdata <= {1'b1, rom_addr[7:0]};
        else if (rom_addr < 16'd6)
            rom_rdata <= img[rom_sel][rom_addr[2:0]];
        else
            rom_rdata <= 9'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input int src, input int x, input int y,
                                input int w0, input int w1, input int w2, input int w3,
                                input int w4, input int w5, input int n, input int lat,
                                input int a0, input int a1, input int a2, input int a3,
                                input int d0, input int d1, input int d2, input int d3);
        vec_t v;
        v.op = op[1:0]; v.src = src[1:0]; v.x = x[9:0]; v.y = y[8:0];
        v.words[0] = w0[8:0]; v.words[1] = w1[8:0]; v.words[2] = w2[8:0];
        v.words[3] = w3[8:0]; v.words[4] = w4[8:0]; v.words[5] = w5[8:0];
        v.n_exp = n; v.lat = lat;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
        return v;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [5:0] glyph,
                           input logic [9:0] x, input logic [8:0] y, output int lat);
        bit ready_low;
        wa.delete(); wd.delete(); ra.delete();
        @(negedge clk);
        chk("ready_before_accept", 32'(req_ready), 1);
        req_valid = 1'b1; req_op = op; req_src = src; req_glyph = glyph; req_x = x; req_y = y;
        @(negedge clk);
        lat = -1;
        ready_low = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            ra.push_back(int'(rom_addr));
            if (req_ready) ready_low = 1'b0;
            if (we) begin
                wa.push_back(int'(waddr));
                wd.push_back(int'(wdata));
            end
            if (done) begin
                lat = cyc;
                break;
            end
            req_op = 2'($urandom); req_src = 2'($urandom); req_glyph = 6'($urandom);
            req_x = 10'($urandom); req_y = 9'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("ready_low_while_busy", 32'(ready_low), 1);
        @(negedge clk);
        chk("ready_after_done", 32'(req_ready), 1);
        chk("idle_no_write", 32'(we), 0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 8; k++)
                img[s][k] = 9'h0;

        vecs[0] = mk(0, 1, 10, 5,    2, 2, 1, 2, 3, 4,       4, 8, 3210, 3211, 3850, 3851, 1, 2, 3, 4);
        vecs[1] = mk(0, 2, 10, 5,    2, 2, 1, 'h88, 3, 4,    3, 8, 3210, 3850, 3851, 0, 1, 3, 4, 0);
        vecs[2] = mk(0, 3, 638, 0,   4, 1, 5, 6, 7, 8,       2, 8, 638, 639, 0, 0, 5, 6, 0, 0);
        vecs[3] = mk(1, 1, 10, 5,    2, 2, 1, 2, 3, 4,       4, 8, 3210, 3211, 3850, 3851, 0, 0, 0, 0);
        vecs[4] = mk(0, 2, 20, 20,   0, 3, 7, 7, 7, 7,       0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(3, 1, 10, 5,    2, 2, 1, 2, 3, 4,       0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(0, 3, 0, 479,   1, 2, 9, 10, 0, 0,      1, 6, 306560, 0, 0, 0, 9, 0, 0, 0);
        vecs[7] = mk(0, 1, 639, 478, 2, 2, 11, 12, 13, 14,   2, 8, 306559, 307199, 0, 0, 11, 13, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 1);
        chk("reset_we", 32'(we), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_waddr", 32'(waddr), 0);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        chk("reset_rom_sel", 32'(rom_sel), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 1);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 6; k++)
                img[vecs[i].src][k] = vecs[i].words[k];
            run_cmd(vecs[i].op, vecs[i].src, 6'd0, vecs[i].x, vecs[i].y, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_writes", i), 32'(wa.size()), 32'(vecs[i].n_exp));
            for (int k = 0; k < vecs[i].n_exp; k++) begin
                chk($sformatf("v%0d_waddr%0d", i, k), (k < wa.size()) ? 32'(wa[k]) : 32'hffffffff,
                    32'(vecs[i].ea[k]));
                chk($sformatf("v%0d_wdata%0d", i, k), (k < wd.size()) ? 32'(wd[k]) : 32'hffffffff,
                    32'(vecs[i].ed[k]));
            end
        end

        run_cmd(2'd2, 2'd1, 6'd3, 10'd0, 9'd0, lat);
        chk("font_latency", 32'(lat), 210);
        chk("font_writes", 32'(wa.size()), 208);
        chk("font_first_rom_addr", (ra.size() > 0) ? 32'(ra[0]) : 32'hffffffff, 39);
        chk("font_row2_rom_addr", (ra.size() > 13) ? 32'(ra[13]) : 32'hffffffff, 583);
        chk("font_first_waddr", (wa.size() > 0) ? 32'(wa[0]) : 32'hffffffff, 0);
        chk("font_first_wdata", (wd.size() > 0) ? 32'(wd[0]) : 32'hffffffff, 256 + 39);
        chk("font_row2_waddr", (wa.size() > 13) ? 32'(wa[13]) : 32'hffffffff, 640);
        chk("font_row2_wdata", (wd.size() > 13) ? 32'(wd[13]) : 32'hffffffff, 256 + 71);
        chk("font_last_waddr", (wa.size() > 207) ? 32'(wa[207]) : 32'hffffffff, 15 * 640 + 12);
        chk("font_rom_sel", 32'(rom_sel), 0);

        for (int k = 0; k < 6; k++)
            img[1][k] = vecs[0].words[k];
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_src = 2'd1; req_x = 10'd10; req_y = 9'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre_we", 32'(we), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_rom_sel", 32'(rom_sel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (we || done) seen = 1'b1;
        end
        chk("rst_no_activity", 32'(seen), 0);
        chk("rst_ready_after", 32'(req_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
